// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous instruction
// memory and registers the fetched word with its PC into IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_instr,
    output logic               ifid_valid,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic in_range;
    logic aligned;
    logic fetch_ok;

    // Anything above the memory's byte span, or not word-aligned, is illegal.
    assign in_range = (pc_q[31:IMEM_AW+2] == '0);
    assign aligned  = (pc_q[1:0] == 2'b00);
    assign fetch_ok = in_range & aligned;

    assign imem_addr = pc_q[IMEM_AW+1:2];

    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;
        count_d      = count_q;
        if (redirect) begin
            pc_d         = redirect_pc;
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            fault_d      = 1'b0;
        end else if (!stall) begin
            pc_d      = pc_q + 32'd4;
            ifid_pc_d = pc_q;
            if (fetch_ok) begin
                ifid_instr_d = imem_data;
                ifid_valid_d = 1'b1;
                fault_d      = 1'b0;
                count_d      = count_q + 32'd1;
            end else begin
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
                fault_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

    assign pc          = pc_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 64-word asynchronous instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];
    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                            input logic [31:0] e_instr, input logic e_vld, input logic e_flt,
                            input logic [31:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".ifid_pc"}, ifid_pc, e_ipc);
        chk({tag, ".instr"}, ifid_instr, e_instr);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_vld});
        chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, e_flt});
        chk({tag, ".count"}, fetch_count, e_cnt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 + i;
        mem[0] = 32'h0000_2103;
        mem[1] = 32'h0040_2183;
        mem[2] = 32'h0000_00B3;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step();
        chk_slot("reset", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 32'd0);
        chk("reset.imem_addr", {26'd0, imem_addr}, 32'd0);
        reset = 1'b0;

        // Free-running fetch of the first three words
        step(); chk_slot("run0", 32'h4, 32'h0, 32'h0000_2103, 1'b1, 1'b0, 32'd1);
        step(); chk_slot("run1", 32'h8, 32'h4, 32'h0040_2183, 1'b1, 1'b0, 32'd2);
        step(); chk_slot("run2", 32'hC, 32'h8, 32'h0000_00B3, 1'b1, 1'b0, 32'd3);
        step(); step(); step();
        chk_slot("run5", 32'h18, 32'h14, 32'hA500_0005, 1'b1, 1'b0, 32'd6);

        // Redirect from 0x18 back to 0x0C flushes the slot
        redirect = 1'b1; redirect_pc = 32'h0C;
        step(); chk_slot("redir", 32'h0C, 32'h18, 32'h13, 1'b0, 1'b0, 32'd6);
        redirect = 1'b0;
        step(); chk_slot("redir.next", 32'h10, 32'h0C, 32'hA500_0003, 1'b1, 1'b0, 32'd7);
        step(); step();
        chk("pre_stall.pc", pc, 32'h18);

        // Two stalled cycles at 0x18, then release
        stall = 1'b1;
        step(); chk_slot("stall0", 32'h18, 32'h14, 32'hA500_0005, 1'b1, 1'b0, 32'd9);
        step(); chk_slot("stall1", 32'h18, 32'h14, 32'hA500_0005, 1'b1, 1'b0, 32'd9);
        stall = 1'b0;
        step(); chk_slot("release", 32'h1C, 32'h18, 32'hA500_0006, 1'b1, 1'b0, 32'd10);

        // Redirect wins over a simultaneous stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
        step(); chk_slot("redir_stall", 32'h20, 32'h1C, 32'h13, 1'b0, 1'b0, 32'd10);
        stall = 1'b0; redirect = 1'b0;
        step(); chk_slot("after_rs", 32'h24, 32'h20, 32'hA500_0008, 1'b1, 1'b0, 32'd11);

        // Misaligned target produces a faulting slot
        redirect = 1'b1; redirect_pc = 32'h0E;
        step(); chk_slot("mis.redir", 32'h0E, 32'h24, 32'h13, 1'b0, 1'b0, 32'd11);
        redirect = 1'b0;
        step(); chk_slot("mis.fault", 32'h12, 32'h0E, 32'h13, 1'b0, 1'b1, 32'd11);

        // Last legal word, then out of range
        redirect = 1'b1; redirect_pc = 32'hFC;
        step(); chk_slot("last.redir", 32'hFC, 32'h12, 32'h13, 1'b0, 1'b0, 32'd11);
        chk("last.imem_addr", {26'd0, imem_addr}, 32'd63);
        redirect = 1'b0;
        step(); chk_slot("last.fetch", 32'h100, 32'hFC, 32'hA500_003F, 1'b1, 1'b0, 32'd12);
        chk("oor.imem_addr", {26'd0, imem_addr}, 32'd0);
        step(); chk_slot("oor.fault", 32'h104, 32'h100, 32'h13, 1'b0, 1'b1, 32'd12);

        // PC wrap through 0xFFFFFFFC
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); chk_slot("wrap.redir", 32'hFFFF_FFFC, 32'h104, 32'h13, 1'b0, 1'b0, 32'd12);
        redirect = 1'b0;
        step(); chk_slot("wrap.fault", 32'h0, 32'hFFFF_FFFC, 32'h13, 1'b0, 1'b1, 32'd12);
        step(); chk_slot("wrap.legal", 32'h4, 32'h0, 32'h0000_2103, 1'b1, 1'b0, 32'd13);

        // Run to 0x24, then reset together with a redirect
        for (int i = 0; i < 8; i++) step();
        chk_slot("pre_reset", 32'h24, 32'h20, 32'hA500_0008, 1'b1, 1'b0, 32'd21);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h50;
        step(); chk_slot("midreset", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0, 32'd0);
        reset = 1'b0; redirect = 1'b0;
        step(); chk_slot("post_reset", 32'h4, 32'h0, 32'h0000_2103, 1'b1, 1'b0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
